// File: rtl/instruction_decoder_pkg.sv
// Shared constants for the A/B accumulator decode stage:
// opcodes, write-source selects, flag bit indices, field slices.
package instruction_decoder_pkg;

   localparam logic [5:0] OP_NOP   = 6'd0;
   localparam logic [5:0] OP_LDA   = 6'd1;
   localparam logic [5:0] OP_LDB   = 6'd2;
   localparam logic [5:0] OP_LDCA  = 6'd3;
   localparam logic [5:0] OP_LDCB  = 6'd4;
   localparam logic [5:0] OP_STA   = 6'd5;
   localparam logic [5:0] OP_STB   = 6'd6;
   localparam logic [5:0] OP_ADDA  = 6'd7;
   localparam logic [5:0] OP_ADDB  = 6'd8;
   localparam logic [5:0] OP_ADDCA = 6'd9;
   localparam logic [5:0] OP_ADDCB = 6'd10;
   localparam logic [5:0] OP_SUBA  = 6'd11;
   localparam logic [5:0] OP_SUBB  = 6'd12;
   localparam logic [5:0] OP_ANDA  = 6'd13;
   localparam logic [5:0] OP_ANDB  = 6'd14;
   localparam logic [5:0] OP_ORA   = 6'd15;
   localparam logic [5:0] OP_ORB   = 6'd16;
   localparam logic [5:0] OP_JMP   = 6'd17;
   localparam logic [5:0] OP_BAEQ  = 6'd18;
   localparam logic [5:0] OP_BBEQ  = 6'd19;

   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_ALU  = 2'b01;
   localparam logic [1:0] SEL_MEM  = 2'b10;
   localparam logic [1:0] SEL_IMM  = 2'b11;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;

   localparam int OP_HI   = 15;
   localparam int OP_LO   = 10;
   localparam int INM_HI  = 7;
   localparam int INM_LO  = 0;
   localparam int MEM_HI  = 9;
   localparam int MEM_LO  = 0;
   localparam int BR_HI   = 5;
   localparam int BR_LO   = 0;
   localparam int JMP_HI  = 9;
   localparam int JMP_LO  = 0;

   typedef struct packed {
      logic [5:0] opcode;
      logic [1:0] sela;
      logic [1:0] selb;
      logic       selm1;
      logic       selm2;
      logic       wr;
      logic       jmp;
      logic       br;
   } ctrl_t;

endpackage

// File: rtl/instruction_decoder_table.sv
// Combinational opcode/flag decode into the control bundle.
// Ports: op, flaga, flagb in; ctrl (ctrl_t) out. Reserved ops give NOP.
module decode_table
   import instruction_decoder_pkg::*;
(
   input  logic [5:0] op,
   input  logic [2:0] flaga,
   input  logic [2:0] flagb,
   output ctrl_t      ctrl
);

   // Only the Z flags steer branches; N/C are carried for later opcodes.
   logic unused_flags;
   assign unused_flags = ^{flaga[FLAG_C:FLAG_N], flagb[FLAG_C:FLAG_N]};

   always_comb begin
      ctrl        = '0;
      ctrl.opcode = op;
      unique case (1'b1)
         (op == OP_NOP): ;
         (op == OP_LDA):  ctrl.sela = SEL_MEM;
         (op == OP_LDB):  ctrl.selb = SEL_MEM;
         (op == OP_LDCA): ctrl.sela = SEL_IMM;
         (op == OP_LDCB): ctrl.selb = SEL_IMM;
         (op == OP_STA):  ctrl.wr = 1'b1;
         (op == OP_STB): begin
            ctrl.wr    = 1'b1;
            ctrl.selm1 = 1'b1;
         end
         (op == OP_ADDA || op == OP_SUBA ||
          op == OP_ANDA || op == OP_ORA):
            ctrl.sela = SEL_ALU;
         (op == OP_ADDB || op == OP_SUBB ||
          op == OP_ANDB || op == OP_ORB): begin
            ctrl.selb  = SEL_ALU;
            ctrl.selm1 = 1'b1;
         end
         (op == OP_ADDCA): begin
            ctrl.sela  = SEL_ALU;
            ctrl.selm2 = 1'b1;
         end
         (op == OP_ADDCB): begin
            ctrl.selb  = SEL_ALU;
            ctrl.selm1 = 1'b1;
            ctrl.selm2 = 1'b1;
         end
         (op == OP_JMP):  ctrl.jmp = 1'b1;
         (op == OP_BAEQ): ctrl.br = flaga[FLAG_Z];
         (op == OP_BBEQ): ctrl.br = flagb[FLAG_Z];
         default:         ctrl.opcode = OP_NOP;
      endcase
   end

endmodule

// File: rtl/instruction_decoder.sv
// Decode stage: registers decoded controls and raw instruction fields.
// Ports: clk, reset, in[15:0], flagA/flagB in; selects, enables, fields out.
module instruction_decoder
   import instruction_decoder_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in,
   input  logic [2:0]  flagA,
   input  logic [2:0]  flagB,
   output logic [5:0]  opCode,
   output logic [1:0]  selA,
   output logic [1:0]  selB,
   output logic        selM1,
   output logic        selM2,
   output logic        wrEnable,
   output logic        jmpEnable,
   output logic        branchEnable,
   output logic [7:0]  inm,
   output logic [9:0]  memDir,
   output logic [5:0]  branchDir,
   output logic [9:0]  jmpDir
);

   ctrl_t ctrl;

   decode_table u_table (
      .op    (in[OP_HI:OP_LO]),
      .flaga (flagA),
      .flagb (flagB),
      .ctrl  (ctrl)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         opCode       <= '0;
         selA         <= '0;
         selB         <= '0;
         selM1        <= 1'b0;
         selM2        <= 1'b0;
         wrEnable     <= 1'b0;
         jmpEnable    <= 1'b0;
         branchEnable <= 1'b0;
         inm          <= '0;
         memDir       <= '0;
         branchDir    <= '0;
         jmpDir       <= '0;
      end else begin
         opCode       <= ctrl.opcode;
         selA         <= ctrl.sela;
         selB         <= ctrl.selb;
         selM1        <= ctrl.selm1;
         selM2        <= ctrl.selm2;
         wrEnable     <= ctrl.wr;
         jmpEnable    <= ctrl.jmp;
         branchEnable <= ctrl.br;
         inm          <= in[INM_HI:INM_LO];
         memDir       <= in[MEM_HI:MEM_LO];
         branchDir    <= in[BR_HI:BR_LO];
         jmpDir       <= in[JMP_HI:JMP_LO];
      end
   end

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder.
// Directed cases plus random instructions against a rule-based model.
module tb_instruction_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in;
   logic [2:0]  flagA;
   logic [2:0]  flagB;
   logic [5:0]  opCode;
   logic [1:0]  selA;
   logic [1:0]  selB;
   logic        selM1;
   logic        selM2;
   logic        wrEnable;
   logic        jmpEnable;
   logic        branchEnable;
   logic [7:0]  inm;
   logic [9:0]  memDir;
   logic [5:0]  branchDir;
   logic [9:0]  jmpDir;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   instruction_decoder dut (
      .clk          (clk),
      .reset        (reset),
      .in           (in),
      .flagA        (flagA),
      .flagB        (flagB),
      .opCode       (opCode),
      .selA         (selA),
      .selB         (selB),
      .selM1        (selM1),
      .selM2        (selM2),
      .wrEnable     (wrEnable),
      .jmpEnable    (jmpEnable),
      .branchEnable (branchEnable),
      .inm          (inm),
      .memDir       (memDir),
      .branchDir    (branchDir),
      .jmpDir       (jmpDir)
   );

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [63:0] outs();
      return {15'd0, opCode, selA, selB, selM1, selM2,
              wrEnable, jmpEnable, branchEnable,
              inm, memDir, branchDir, jmpDir};
   endfunction

   // Expected outputs derived from the instruction-set rules.
   function automatic logic [63:0] model(input logic rst,
                                         input logic [15:0] i,
                                         input logic [2:0] fa,
                                         input logic [2:0] fb);
      int o;
      logic [5:0] oc;
      logic [1:0] sa, sb;
      logic m1, m2, wr, jp, br;
      o  = int'(i >> 10);
      sa = 0; sb = 0; m1 = 0; m2 = 0;
      wr = 0; jp = 0; br = 0;
      if (rst) return 64'd0;
      oc = (o <= 19) ? 6'(o) : 6'd0;
      if (o == 1) sa = 2;
      if (o == 2) sb = 2;
      if (o == 3) sa = 3;
      if (o == 4) sb = 3;
      if (o == 5 || o == 6) wr = 1;
      if (o == 6) m1 = 1;
      if (o >= 7 && o <= 16) begin
         if (o == 9 || o == 10) m2 = 1;
         if (o % 2 == 1) sa = 1;
         else begin
            sb = 1;
            m1 = 1;
         end
      end
      if (o == 17) jp = 1;
      if (o == 18) br = fa[0];
      if (o == 19) br = fb[0];
      return {15'd0, oc, sa, sb, m1, m2, wr, jp, br,
              i[7:0], i[9:0], i[5:0], i[9:0]};
   endfunction

   task automatic step(input logic rst, input logic [15:0] i,
                       input logic [2:0] fa, input logic [2:0] fb,
                       input string tag);
      @(negedge clk);
      reset = rst;
      in    = i;
      flagA = fa;
      flagB = fb;
      @(posedge clk);
      #1;
      check(tag, outs(), model(rst, i, fa, fb));
   endtask

   initial begin
      reset = 1'b1;
      in    = 16'h0000;
      flagA = 3'b000;
      flagB = 3'b000;

      step(1'b1, 16'h0400, 3'b000, 3'b000, "reset");
      check("reset_zero", outs(), 64'd0);
      step(1'b0, 16'h0400, 3'b000, 3'b000, "release");
      check("release_op", {58'd0, opCode}, 64'd1);
      check("release_selA", {62'd0, selA}, 64'd2);

      for (int op = 0; op < 20; op++) begin
         step(1'b0, {6'(op), 10'h080}, 3'b000, 3'b000,
              $sformatf("sweep_%0d", op));
         check($sformatf("sweep_inm_%0d", op), {56'd0, inm}, 64'h80);
         check($sformatf("sweep_bd_%0d", op), {58'd0, branchDir}, 64'h0);
      end

      step(1'b0, {6'd18, 10'h02a}, 3'b001, 3'b000, "baeq_taken");
      check("baeq_en", {63'd0, branchEnable}, 64'd1);
      check("baeq_dir", {58'd0, branchDir}, 64'h2a);
      step(1'b0, {6'd18, 10'h02a}, 3'b110, 3'b001, "baeq_not");
      check("baeq_off", {63'd0, branchEnable}, 64'd0);
      step(1'b0, {6'd19, 10'h015}, 3'b000, 3'b001, "bbeq_taken");
      check("bbeq_en", {63'd0, branchEnable}, 64'd1);
      step(1'b0, {6'd19, 10'h015}, 3'b001, 3'b110, "bbeq_not");
      check("bbeq_off", {63'd0, branchEnable}, 64'd0);

      step(1'b0, 16'h4555, 3'b111, 3'b111, "jmp");
      check("jmp_en", {61'd0, jmpEnable, wrEnable, branchEnable},
            64'b100);
      check("jmp_dir", {54'd0, jmpDir}, 64'h155);

      step(1'b0, {6'd20, 10'h3c5}, 3'b111, 3'b111, "rsv20");
      check("rsv20_op", {58'd0, opCode}, 64'd0);
      step(1'b0, {6'd63, 10'h1a7}, 3'b111, 3'b111, "rsv63");
      check("rsv63_mem", {54'd0, memDir}, 64'h1a7);

      step(1'b0, {6'd5, 10'h011}, 3'b000, 3'b000, "sta");
      check("sta_wr", {63'd0, wrEnable}, 64'd1);
      step(1'b0, {6'd4, 2'b00, 8'hff}, 3'b000, 3'b000, "ldcb");
      check("ldcb_wr", {63'd0, wrEnable}, 64'd0);
      check("ldcb_selB", {62'd0, selB}, 64'd3);
      check("ldcb_inm", {56'd0, inm}, 64'hff);

      for (int n = 0; n < 300; n++) begin
         logic [15:0] ri;
         ri = 16'($urandom);
         if (n % 2 == 0) ri[15:10] = 6'($urandom_range(0, 21));
         step(($urandom_range(0, 15) == 0), ri,
              3'($urandom), 3'($urandom), "random");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
